// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if
// Purpose : groups the connections between the multicycle control sequencer
//           and the yIF/yID/yEX/yDM/yWB/yPC datapath.
// Signals : ins/zero            datapath -> sequencer (instruction word, ALU zero flag)
//           RegDst..pc_we       sequencer -> datapath control lines and PC strobes
//           retired, halted     sequencer status
// Modports: master = sequencer side, slave = datapath side.
interface mc_control_fsm_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      ins;
    logic             zero;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrc;
    logic             Mem2Reg;
    logic             MemRead;
    logic             MemWrite;
    logic [2:0]       op;
    logic             branch;
    logic             jump;
    logic             INT;
    logic             pc_we;
    logic [CNT_W-1:0] retired;
    logic             halted;

    modport master (
        input  ins, zero,
        output RegDst, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, op,
        output branch, jump, INT, pc_we, retired, halted
    );

    modport slave (
        output ins, zero,
        input  RegDst, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, op,
        input  branch, jump, INT, pc_we, retired, halted
    );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
// Purpose : multicycle control sequencer. Captures each fetched instruction, steps it
//           through FETCH..WB and drives every datapath control line, the PC write
//           strobe and the reset-time entry-point load. Halts after MAX_INS retirements.
// Ports   : clk    datapath clock, all state on rising edge
//           rst_n  synchronous active-low reset
//           bus    mc_control_fsm_if.master (ins/zero in; controls, pc_we, retired,
//                  halted out)
// Params  : MAX_INS  instructions to retire before HALT (0 = run forever)
//           CNT_W    width of the retired-instruction counter
// Config  : define ILLEGAL_TRAP_EN to make unknown encodings reload the entry point
//           (INT=1, pc_we=1 in DECODE); otherwise they retire as 2-cycle NOPs.
module mc_control_fsm #(
    parameter int unsigned MAX_INS = 43,
    parameter int unsigned CNT_W   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    mc_control_fsm_if.master bus
);

    typedef enum logic [2:0] {
        StBoot, StFetch, StDecode, StExec, StMem, StWb, StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsRAdd, ClsROr, ClsAddi, ClsLw, ClsSw, ClsBeq, ClsJ, ClsIll
    } cls_e;

    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic       mem2reg;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] op;
        logic       branch;
        logic       jump;
        logic       intr;
        logic       pc_we;
        logic       halted;
    } ctrl_t;

    localparam logic [CNT_W-1:0] MaxInsW = CNT_W'(MAX_INS);
    localparam logic [CNT_W-1:0] OneW    = CNT_W'(1);

    // Only the opcode and funct fields steer the sequencer, so only they are kept.
    logic [11:0]      ir_q, ir_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d, retired_inc;
    ctrl_t            ctrl_q, ctrl_d;
    cls_e             cls_q;
    logic             term;

    function automatic cls_e decode(input logic [11:0] ir);
        cls_e c;
        case (ir[11:6])
            6'h00:   c = (ir[5:0] == 6'h20) ? ClsRAdd :
                         (ir[5:0] == 6'h25) ? ClsROr  : ClsIll;
            6'h08:   c = ClsAddi;
            6'h23:   c = ClsLw;
            6'h2b:   c = ClsSw;
            6'h04:   c = ClsBeq;
            6'h02:   c = ClsJ;
            default: c = ClsIll;
        endcase
        return c;
    endfunction

    // Last state of each instruction class: PC is written and the retire counter bumps.
    function automatic logic is_term(input state_e st, input cls_e cls);
        logic t;
        case (st)
            StDecode: t = (cls == ClsJ) || (cls == ClsIll);
            StExec:   t = (cls == ClsBeq);
            StMem:    t = (cls == ClsSw);
            StWb:     t = 1'b1;
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

    // Idle levels: all strobes low, ALU B from immediate, ALU adds.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c         = '0;
        c.alu_src = 1'b1;
        c.op      = 3'b010;
        return c;
    endfunction

    // Moore control word for a (state, instruction class) pair.
    function automatic ctrl_t ctrl_for(input state_e st, input cls_e cls);
        ctrl_t c;
        c = ctrl_idle();
        case (st)
            StBoot: begin
                c.intr  = 1'b1;
                c.pc_we = 1'b1;
            end
            StDecode, StExec, StMem, StWb: begin
                // Datapath selects are held for the whole life of the instruction.
                case (cls)
                    ClsRAdd: begin
                        c.alu_src = 1'b0;
                        c.reg_dst = 1'b1;
                    end
                    ClsROr: begin
                        c.alu_src = 1'b0;
                        c.reg_dst = 1'b1;
                        c.op      = 3'b001;
                    end
                    ClsBeq: begin
                        c.alu_src = 1'b0;
                        c.op      = 3'b110;
                    end
                    default: ;
                endcase
                c.jump      = (st == StDecode) && (cls == ClsJ);
                c.branch    = (st == StExec) && (cls == ClsBeq);
                c.mem_write = (st == StMem) && (cls == ClsSw);
                c.mem_read  = (cls == ClsLw) && ((st == StMem) || (st == StWb));
                c.reg_write = (st == StWb);
                c.mem2reg   = (st == StWb) && (cls == ClsLw);
                c.pc_we     = is_term(st, cls);
`ifdef ILLEGAL_TRAP_EN
                c.intr      = (st == StDecode) && (cls == ClsIll);
`endif
            end
            StHalt: c.halted = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    assign cls_q       = decode(ir_q);
    assign term        = is_term(state_q, cls_q);
    assign retired_inc = retired_q + OneW;

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        case (state_q)
            // Stay one extra cycle after reset so the entry-point load is visible.
            StBoot:   state_d = ctrl_q.intr ? StFetch : StBoot;
            StFetch: begin
                ir_d    = {bus.ins[31:26], bus.ins[5:0]};
                state_d = StDecode;
            end
            StDecode: state_d = StExec;
            StExec:   state_d = ((cls_q == ClsLw) || (cls_q == ClsSw)) ? StMem : StWb;
            StMem:    state_d = StWb;
            StWb:     state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StBoot;
        endcase
        if (term) begin
            retired_d = retired_inc;
            state_d   = ((MAX_INS != 0) && (retired_inc == MaxInsW)) ? StHalt : StFetch;
        end
        ctrl_d = ctrl_for(state_d, decode(ir_d));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StBoot;
            ir_q      <= '0;
            retired_q <= '0;
            ctrl_q    <= ctrl_idle();
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign bus.RegDst   = ctrl_q.reg_dst;
    assign bus.RegWrite = ctrl_q.reg_write;
    assign bus.ALUSrc   = ctrl_q.alu_src;
    assign bus.Mem2Reg  = ctrl_q.mem2reg;
    assign bus.MemRead  = ctrl_q.mem_read;
    assign bus.MemWrite = ctrl_q.mem_write;
    assign bus.op       = ctrl_q.op;
    assign bus.branch   = ctrl_q.branch;
    assign bus.jump     = ctrl_q.jump;
    assign bus.INT      = ctrl_q.intr;
    assign bus.pc_we    = ctrl_q.pc_we;
    assign bus.retired  = retired_q;
    assign bus.halted   = ctrl_q.halted;

    // yPC consumes zero directly; the register fields of ins are datapath business.
    logic unused_ins;
    assign unused_ins = ^{bus.ins[25:6], bus.zero};

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;
    localparam int unsigned MaxIns = 20;
    localparam int unsigned CntW   = 16;
    localparam int          NDir   = 8;

    typedef struct {
        logic [31:0] w;
        int          lat;
        logic [7:0]  rw, mr, mw, m2r, br, jp, intr;
        int          key;
        bit          sel;
        logic [2:0]  op;
        logic        src, dst;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_control_fsm_if #(.CNT_W(CntW)) bus ();

    mc_control_fsm #(.MAX_INS(MaxIns), .CNT_W(CntW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    int presented = 0;
    int retire_cnt = 0;
    int exp_ret = 0;
    bit mon_en = 0, load_first = 0, use_fixed = 0, ret_pend = 0;
    int cyc = 0;
    logic [7:0] o_rw, o_mr, o_mw, o_m2r, o_br, o_jp, o_int;
    logic [2:0] o_op [8];
    logic       o_src [8];
    logic       o_dst [8];

    logic [31:0] dir_prog [NDir] = '{32'h00A64820, 32'h8C090004, 32'hAC090004, 32'h11090002,
                                     32'h08000020, 32'hFC000000, 32'h00853025, 32'h2109FFFF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] at(input int c);
        return 8'b1 << (c - 1);
    endfunction

    // Reference: latency and the cycles (1 = FETCH) where each strobe must be high.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic [5:0] opc, fn;
        opc = w[31:26];
        fn  = w[5:0];
        e.w = w; e.lat = 2; e.key = 1; e.sel = 0; e.op = 3'b010; e.src = 1; e.dst = 0;
        e.rw = 0; e.mr = 0; e.mw = 0; e.m2r = 0; e.br = 0; e.jp = 0; e.intr = 0;
        if (opc == 6'h00 && (fn == 6'h20 || fn == 6'h25)) begin
            e.lat = 4; e.rw = at(4); e.key = 4; e.sel = 1;
            e.op = (fn == 6'h20) ? 3'b010 : 3'b001; e.src = 0; e.dst = 1;
        end else if (opc == 6'h08) begin
            e.lat = 4; e.rw = at(4); e.key = 4; e.sel = 1;
        end else if (opc == 6'h23) begin
            e.lat = 5; e.mr = at(4) | at(5); e.m2r = at(5); e.rw = at(5);
        end else if (opc == 6'h2b) begin
            e.lat = 4; e.mw = at(4);
        end else if (opc == 6'h04) begin
            e.lat = 3; e.br = at(3); e.key = 3; e.sel = 1; e.op = 3'b110; e.src = 0;
        end else if (opc == 6'h02) begin
            e.jp = at(2);
        end else begin
`ifdef ILLEGAL_TRAP_EN
            e.intr = at(2);
`endif
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return {6'h00, r[25:6], 6'h20};
            1: return {6'h00, r[25:6], 6'h25};
            2: return {6'h08, r[25:0]};
            3: return {6'h23, r[25:0]};
            4: return {6'h2b, r[25:0]};
            5: return {6'h04, r[25:0]};
            6: return {6'h02, r[25:0]};
            default: return r[0] ? {6'h3F, r[25:0]} : {6'h00, r[25:6], 6'h22};
        endcase
    endfunction

    task automatic present_next();
        logic [31:0] w;
        if (use_fixed) begin
            w = 32'h8C090004;
        end else begin
            w = (presented < NDir) ? dir_prog[presented] : rand_ins();
            exp_q.push_back(model(w));
            presented++;
        end
        bus.ins = w;
    endtask

    // Datapath stand-in: new instruction after each retirement, random zero flag.
    always @(negedge clk) begin
        bus.zero = 1'($urandom_range(0, 1));
        if (load_first || (mon_en && bus.pc_we && presented < int'(MaxIns)))
            present_next();
    end

    // Monitor: collects strobes per instruction, compares on each pc_we.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ret_pend) begin
                check("retired", 32'(bus.retired), exp_ret);
                ret_pend = 0;
            end
            cyc++;
            if (cyc <= 8) begin
                o_rw[cyc-1] = bus.RegWrite;  o_mr[cyc-1] = bus.MemRead;
                o_mw[cyc-1] = bus.MemWrite;  o_m2r[cyc-1] = bus.Mem2Reg;
                o_br[cyc-1] = bus.branch;    o_jp[cyc-1] = bus.jump;
                o_int[cyc-1] = bus.INT;      o_op[cyc-1] = bus.op;
                o_src[cyc-1] = bus.ALUSrc;   o_dst[cyc-1] = bus.RegDst;
            end
            if (bus.pc_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("lat %h", e.w), cyc, e.lat);
                    check($sformatf("RegWrite %h", e.w), o_rw, e.rw);
                    check($sformatf("MemRead %h", e.w), o_mr, e.mr);
                    check($sformatf("MemWrite %h", e.w), o_mw, e.mw);
                    check($sformatf("Mem2Reg %h", e.w), o_m2r, e.m2r);
                    check($sformatf("branch %h", e.w), o_br, e.br);
                    check($sformatf("jump %h", e.w), o_jp, e.jp);
                    check($sformatf("INT %h", e.w), o_int, e.intr);
                    if (e.sel && e.key <= cyc) begin
                        check($sformatf("op %h", e.w), o_op[e.key-1], e.op);
                        check($sformatf("ALUSrc %h", e.w), o_src[e.key-1], e.src);
                        check($sformatf("RegDst %h", e.w), o_dst[e.key-1], e.dst);
                    end
                end
                exp_ret++;
                retire_cnt++;
                ret_pend = 1;
                cyc = 0;
                {o_rw, o_mr, o_mw, o_m2r, o_br, o_jp, o_int} = '0;
            end else if (cyc > 8) begin
                check("retire_timeout", 0, 1);
                cyc = 0;
                {o_rw, o_mr, o_mw, o_m2r, o_br, o_jp, o_int} = '0;
            end
        end
    end

    task automatic check_reset_outs(input string tag);
        check({tag, " INT"}, bus.INT, 0);
        check({tag, " pc_we"}, bus.pc_we, 0);
        check({tag, " RegWrite"}, bus.RegWrite, 0);
        check({tag, " MemRead"}, bus.MemRead, 0);
        check({tag, " MemWrite"}, bus.MemWrite, 0);
        check({tag, " ALUSrc"}, bus.ALUSrc, 1);
        check({tag, " op"}, bus.op, 3'b010);
        check({tag, " retired"}, 32'(bus.retired), 0);
        check({tag, " halted"}, bus.halted, 0);
    endtask

    initial begin
        {o_rw, o_mr, o_mw, o_m2r, o_br, o_jp, o_int} = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk);
        load_first = 1;
        @(negedge clk);
        check_reset_outs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        load_first = 0;
        @(negedge clk);
        check("boot INT", bus.INT, 1);
        check("boot pc_we", bus.pc_we, 1);
        check("boot RegWrite", bus.RegWrite, 0);
        @(posedge clk);
        mon_en = 1;
        for (int i = 0; i < 1000 && retire_cnt < int'(MaxIns); i++) @(negedge clk);
        check("retire_count", retire_cnt, MaxIns);
        @(posedge clk);
        mon_en = 0;
        check("queue_drained", exp_q.size(), 0);
        repeat (5) begin
            @(negedge clk);
            check("halt halted", bus.halted, 1);
            check("halt pc_we", bus.pc_we, 0);
            check("halt retired", 32'(bus.retired), MaxIns);
        end

        // Reset while a lw sits in MEM: the pending writeback must be dropped.
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        use_fixed = 1;
        load_first = 1;
        @(negedge clk);
        check_reset_outs("reset2");
        rst_n = 1'b1;
        @(posedge clk);
        load_first = 0;
        @(negedge clk);
        check("boot2 INT", bus.INT, 1);
        repeat (4) @(negedge clk);
        check("lw MEM MemRead", bus.MemRead, 1);
        check("lw MEM RegWrite", bus.RegWrite, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort RegWrite", bus.RegWrite, 0);
        check("abort MemRead", bus.MemRead, 0);
        check("abort pc_we", bus.pc_we, 0);
        check("abort retired", 32'(bus.retired), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort boot INT", bus.INT, 1);
        check("abort boot RegWrite", bus.RegWrite, 0);
        @(negedge clk);
        check("abort fetch RegWrite", bus.RegWrite, 0);
        check("abort fetch INT", bus.INT, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
